// File: rtl/sc_fir_engine.sv
// sc_fir_engine
//   Stochastic-computing FIR dot-product engine. A conversion runs for
//   2**N cycles. In each cycle a weighted random selector picks one tap.
//   That tap's sample is turned into a stochastic bit by comparing it
//   against a random value. The bit is sign-corrected and then counted.
//   The final count is reported as either a unipolar or a bipolar value.
//
// Ports
//   clock      rising-edge clock
//   reset      synchronous, active-high
//   start      begin a conversion (only honoured in IDLE)
//   x_in       packed unsigned samples, tap k at [k*(N+1) +: N+1]
//   cum_w      packed cumulative selection thresholds, tap k at [k*N +: N]
//   sign_mask  1 = negative coefficient (stochastic bit inverted)
//   bipolar    0 = unipolar result, 1 = bipolar result
//   busy       high while the stream is being generated
//   done       one-cycle pulse, coincident with a fresh result
//   result     signed result, held until the next done or reset
//
// N is supported from 2 to 16 (the range of the LFSR polynomial table).
module sc_fir_engine #(
  parameter int          N      = 12,
  parameter int          TAPS   = 19,
  parameter logic [N-1:0] SEED_X = N'(12'hACE),
  parameter logic [N-1:0] SEED_S = N'(12'h5B3)
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     start,
  input  logic [TAPS*(N+1)-1:0]    x_in,
  input  logic [TAPS*N-1:0]        cum_w,
  input  logic [TAPS-1:0]          sign_mask,
  input  logic                     bipolar,
  output logic                     busy,
  output logic                     done,
  output logic signed [N+1:0]      result
);

  localparam int SW = (TAPS > 1) ? $clog2(TAPS) : 1;

  // Galois feedback masks (right-shifting form) for maximal-length LFSRs.
  function automatic logic [15:0] poly_of(input int n);
    case (n)
      2:       poly_of = 16'h0003;
      3:       poly_of = 16'h0006;
      4:       poly_of = 16'h000C;
      5:       poly_of = 16'h0014;
      6:       poly_of = 16'h0030;
      7:       poly_of = 16'h0060;
      8:       poly_of = 16'h00B8;
      9:       poly_of = 16'h0110;
      10:      poly_of = 16'h0240;
      11:      poly_of = 16'h0500;
      12:      poly_of = 16'h0E08;
      13:      poly_of = 16'h1C80;
      14:      poly_of = 16'h3802;
      15:      poly_of = 16'h6000;
      16:      poly_of = 16'hD008;
      default: poly_of = 16'h0000;
    endcase
  endfunction

  localparam logic [N-1:0] POLY = N'(poly_of(N));
  // 2**N: the offset that is subtracted in bipolar mode.
  localparam logic [N+1:0] HALF = (N+2)'(1) << N;

  function automatic logic [N-1:0] lfsr_step(input logic [N-1:0] s);
    lfsr_step = {1'b0, s[N-1:1]} ^ (s[0] ? POLY : '0);
  endfunction

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t                   state_q,  state_d;
  logic [TAPS*(N+1)-1:0]    x_q,      x_d;
  logic [TAPS*N-1:0]        w_q,      w_d;
  logic [TAPS-1:0]          sign_q,   sign_d;
  logic                     bip_q,    bip_d;
  logic [N-1:0]             lfsr_x_q, lfsr_x_d;
  logic [N-1:0]             lfsr_s_q, lfsr_s_d;
  logic [N:0]               count_q,  count_d;
  logic [N-1:0]             cycle_q,  cycle_d;
  logic signed [N+1:0]      result_q, result_d;

  // Per-tap threshold hits and stochastic bits. Both are evaluated in
  // parallel, and the selector below picks one of them.
  logic [TAPS-1:0] hit;
  logic [TAPS-1:0] stoch;

  generate
    for (genvar gi = 0; gi < TAPS; gi++) begin : g_tap
      assign hit[gi]   = lfsr_s_q < w_q[gi*N +: N];
      assign stoch[gi] = (x_q[gi*(N+1) +: (N+1)] > {1'b0, lfsr_x_q}) ^ sign_q[gi];
    end
  endgenerate

  // The lowest hitting index wins. When no tap hits, the last tap is used.
  // A zero threshold can never hit because an LFSR never holds zero.
  logic [SW-1:0] sel;
  logic          sb;

  always_comb begin
    sel = SW'(TAPS-1);
    for (int k = TAPS-1; k >= 0; k--) begin
      if (hit[k]) sel = SW'(k);
    end
    sb = stoch[sel];
  end

  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    w_d      = w_q;
    sign_d   = sign_q;
    bip_d    = bip_q;
    lfsr_x_d = lfsr_x_q;
    lfsr_s_d = lfsr_s_q;
    count_d  = count_q;
    cycle_d  = cycle_q;
    result_d = result_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          x_d      = x_in;
          w_d      = cum_w;
          sign_d   = sign_mask;
          bip_d    = bipolar;
          count_d  = '0;
          cycle_d  = '0;
          lfsr_x_d = SEED_X;
          lfsr_s_d = SEED_S;
          state_d  = ST_RUN;
        end
      end

      ST_RUN: begin
        count_d  = count_q + (N+1)'(sb);
        cycle_d  = cycle_q + 1'b1;
        lfsr_x_d = lfsr_step(lfsr_x_q);
        lfsr_s_d = lfsr_step(lfsr_s_q);
        if (cycle_q == '1) begin
          state_d = ST_DONE;
          // The result is loaded together with the last count. This makes it
          // valid in the same cycle as the done pulse.
          if (bip_q) result_d = $signed({count_d, 1'b0} - HALF);
          else       result_d = $signed({1'b0, count_d});
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      x_q      <= '0;
      w_q      <= '0;
      sign_q   <= '0;
      bip_q    <= 1'b0;
      lfsr_x_q <= SEED_X;
      lfsr_s_q <= SEED_S;
      count_q  <= '0;
      cycle_q  <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      w_q      <= w_d;
      sign_q   <= sign_d;
      bip_q    <= bip_d;
      lfsr_x_q <= lfsr_x_d;
      lfsr_s_q <= lfsr_s_d;
      count_q  <= count_d;
      cycle_q  <= cycle_d;
      result_q <= result_d;
    end
  end

  assign busy   = (state_q == ST_RUN);
  assign done   = (state_q == ST_DONE);
  assign result = result_q;

endmodule

// File: tb/tb_sc_fir_engine.sv
// Testbench for sc_fir_engine with N=4, TAPS=3.
module tb_sc_fir_engine;

  localparam int N    = 4;
  localparam int TAPS = 3;
  localparam logic [3:0] SX = 4'hE;
  localparam logic [3:0] SS = 4'h3;

  logic               clock = 1'b0;
  logic               reset;
  logic               start;
  logic [14:0]        x_in;
  logic [11:0]        cum_w;
  logic [2:0]         sign_mask;
  logic               bipolar;
  logic               busy;
  logic               done;
  logic signed [5:0]  result;

  int n_checks = 0;
  int n_fail   = 0;

  sc_fir_engine #(
    .N(N), .TAPS(TAPS), .SEED_X(SX), .SEED_S(SS)
  ) dut (
    .clock(clock), .reset(reset), .start(start), .x_in(x_in),
    .cum_w(cum_w), .sign_mask(sign_mask), .bipolar(bipolar),
    .busy(busy), .done(done), .result(result)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [14:0]       x;
    logic [11:0]       w;
    logic [2:0]        sg;
    logic              bp;
    logic signed [5:0] exp;
  } vec_t;

  vec_t tbl[8];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference model. It walks the 2**N stream directly. The random sources
  // are the N-bit maximal-length sequences x^4+x^3+1, started from the seeds.
  function automatic int model(input logic [14:0] xp, input logic [11:0] wp,
                               input logic [2:0] sg, input logic bp);
    int rx = int'(SX);
    int rs = int'(SS);
    int cnt = 0;
    for (int c = 0; c < 16; c++) begin
      int k = 2;
      bit found = 0;
      for (int j = 0; j < 3; j++) begin
        if (!found && rs < int'(wp[j*4 +: 4])) begin
          k = j;
          found = 1;
        end
      end
      if ((int'(xp[k*5 +: 5]) > rx) != sg[k]) cnt++;
      rx = (rx % 2 == 1) ? ((rx / 2) ^ 12) : (rx / 2);
      rs = (rs % 2 == 1) ? ((rs / 2) ^ 12) : (rs / 2);
    end
    return bp ? (2 * cnt - 16) : cnt;
  endfunction

  // Runs one conversion. Start is sampled at edge P0. RUN cycle n is observed
  // at the n-th falling edge after P0, and done is expected at n = 17.
  // With disturb set, start is pulsed during RUN cycles 3 and 16, and the
  // inputs are scrambled during RUN cycle 5.
  task automatic run_conv(input logic [14:0] xp, input logic [11:0] wp,
                          input logic [2:0] sg, input logic bp, input bit disturb,
                          output int res, output int lat, output int busy_ok);
    @(negedge clock);
    x_in = xp; cum_w = wp; sign_mask = sg; bipolar = bp; start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    lat = 0;
    busy_ok = 1;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clock);
      if (disturb) begin
        if (n == 3 || n == 16) start = 1'b1;
        if (n == 4 || n == 17) start = 1'b0;
        if (n == 5) begin
          x_in = 15'($urandom); cum_w = 12'($urandom);
          sign_mask = 3'($urandom); bipolar = ~bp;
        end
      end
      if (done) begin
        lat = n;
        if (busy) busy_ok = 0;
        break;
      end
      if (!busy) busy_ok = 0;
    end
    start = 1'b0;
    res = int'(result);
  endtask

  initial begin
    int res, lat, bok, res2, lat2, bok2, exp;
    logic [14:0] rx15;
    logic [11:0] rw12;
    logic [2:0]  rsg;
    logic        rbp;
    int          done_seen;

    tbl[0] = '{x: {5'd16, 5'd16, 5'd16}, w: {4'd15, 4'd10, 4'd5}, sg: 3'b000, bp: 1'b0, exp: 6'sd16};
    tbl[1] = '{x: 15'd0,                 w: {4'd12, 4'd8, 4'd4},  sg: 3'b111, bp: 1'b1, exp: 6'sd16};
    tbl[2] = '{x: 15'd0,                 w: {4'd12, 4'd8, 4'd4},  sg: 3'b000, bp: 1'b1, exp: -6'sd16};
    tbl[3] = '{x: {5'd16, 5'd0, 5'd0},   w: 12'd0,                sg: 3'b000, bp: 1'b0, exp: 6'sd16};
    tbl[4] = '{x: {5'd0, 5'd16, 5'd16},  w: 12'd0,                sg: 3'b000, bp: 1'b0, exp: 6'sd0};
    tbl[5] = '{x: {5'd16, 5'd0, 5'd0},   w: 12'd0,                sg: 3'b100, bp: 1'b1, exp: -6'sd16};
    // With all thresholds at 15, tap 0 is taken except when rs == 15 (once).
    tbl[6] = '{x: {5'd0, 5'd0, 5'd16},   w: 12'hFFF,              sg: 3'b000, bp: 1'b0, exp: 6'sd15};
    tbl[7] = '{x: {5'd0, 5'd0, 5'd16},   w: 12'hFFF,              sg: 3'b000, bp: 1'b1, exp: 6'sd14};

    reset = 1'b1; start = 1'b0; x_in = '0; cum_w = '0; sign_mask = '0; bipolar = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_result", int'(result), 0);
    reset = 1'b0;

    for (int i = 0; i < 8; i++) begin
      run_conv(tbl[i].x, tbl[i].w, tbl[i].sg, tbl[i].bp, 1'b0, res, lat, bok);
      $display("vec %0d: result=%0d latency=%0d busy_ok=%0d", i, res, lat, bok);
      chk($sformatf("vec%0d_result", i), res, int'(tbl[i].exp));
      chk($sformatf("vec%0d_latency", i), lat, 17);
      chk($sformatf("vec%0d_busy", i), bok, 1);
    end

    for (int i = 0; i < 6; i++) begin
      rx15 = {5'($urandom_range(16)), 5'($urandom_range(16)), 5'($urandom_range(16))};
      rw12 = 12'($urandom);
      rsg  = 3'($urandom);
      rbp  = 1'($urandom);
      exp  = model(rx15, rw12, rsg, rbp);
      run_conv(rx15, rw12, rsg, rbp, 1'b0, res, lat, bok);
      run_conv(rx15, rw12, rsg, rbp, 1'b0, res2, lat2, bok2);
      $display("rand %0d: first=%0d second=%0d model=%0d", i, res, res2, exp);
      chk($sformatf("rand%0d_first", i), res, exp);
      chk($sformatf("rand%0d_second", i), res2, exp);
      chk($sformatf("rand%0d_latency", i), lat2, 17);
    end

    // Start pulses and input changes during RUN have no effect.
    rx15 = {5'd9, 5'd3, 5'd14};
    rw12 = {4'd15, 4'd11, 4'd6};
    rsg  = 3'b010;
    rbp  = 1'b1;
    exp  = model(rx15, rw12, rsg, rbp);
    run_conv(rx15, rw12, rsg, rbp, 1'b1, res, lat, bok);
    $display("disturb: result=%0d latency=%0d model=%0d", res, lat, exp);
    chk("disturb_result", res, exp);
    chk("disturb_latency", lat, 17);
    @(negedge clock);
    chk("disturb_no_restart", int'(busy), 0);

    // Abort a conversion with reset in RUN cycle 5.
    run_conv({5'd16, 5'd16, 5'd16}, 12'h000, 3'b000, 1'b0, 1'b0, res, lat, bok);
    chk("pre_abort_result", res, 16);
    @(negedge clock);
    x_in = {5'd7, 5'd2, 5'd11}; cum_w = 12'h9A4; sign_mask = 3'b001; bipolar = 1'b0; start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    repeat (5) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    $display("abort: busy=%0d done=%0d result=%0d", busy, done, result);
    chk("abort_busy", int'(busy), 0);
    chk("abort_result", int'(result), 0);
    done_seen = 0;
    repeat (20) begin
      @(negedge clock);
      if (done) done_seen = 1;
    end
    chk("abort_no_done", done_seen, 0);

    rx15 = {5'd5, 5'd16, 5'd1};
    rw12 = {4'd0, 4'd9, 4'd3};
    rsg  = 3'b001;
    rbp  = 1'b0;
    exp  = model(rx15, rw12, rsg, rbp);
    run_conv(rx15, rw12, rsg, rbp, 1'b0, res, lat, bok);
    $display("after_abort: result=%0d model=%0d", res, exp);
    chk("after_abort_result", res, exp);
    chk("after_abort_latency", lat, 17);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
